// File: rtl/hpsfpga_sw_pkg.sv
// Shared definitions for the slide-switch interrupt controller.
//   ADDR_*      : Avalon-MM word addresses of the register map.
//   db_state_e  : per-bit debounce FSM state.
package hpsfpga_sw_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RAW     = 2'd3;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/hpsfpga_sw_debounce_bit.sv
// One switch input: two-flop synchroniser followed by a counting debouncer.
//   clk, reset_n : clock, async active-low reset
//   in_raw       : asynchronous switch level
//   sync_o       : synchronised (undebounced) level
//   stable_o     : debounced level
module hpsfpga_sw_debounce_bit
  import hpsfpga_sw_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_raw,
  output logic sync_o,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_e        state_q, state_d;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples
  // that differ from the current stable level; any agreeing sample restarts.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      DB_STABLE: begin
        cnt_d = '0;
        if (sync2_q != stable_q) begin
          state_d = DB_COUNTING;
          cnt_d   = CNT_W'(1);
        end
      end
      DB_COUNTING: begin
        if (sync2_q == stable_q) begin
          state_d = DB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DB_STABLE;
          cnt_d    = '0;
          stable_d = sync2_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      state_q  <= DB_STABLE;
    end else begin
      sync1_q  <= in_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign sync_o   = sync2_q;
  assign stable_o = stable_q;

endmodule

// File: rtl/hpsfpga_sw_irq_ctrl.sv
// Avalon-MM slave for the slide switches: debounced DATA, IRQMASK,
// W1C EDGECAPTURE, RAW synchronised levels, and a level interrupt.
//   clk, reset_n                       : clock, async active-low reset
//   address/chipselect/write_n/writedata: Avalon-MM slave, write = cs & !write_n
//   readdata                           : registered read data, latency 1
//   in_port                            : raw switch levels
//   irq                                : |(edgecapture & irqmask), registered
module hpsfpga_sw_irq_ctrl
  import hpsfpga_sw_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable, raw;
  logic [WIDTH-1:0] stable_dly_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr;
  logic             unused_wd;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      hpsfpga_sw_debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_db (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_raw   (in_port[gi]),
        .sync_o   (raw[gi]),
        .stable_o (stable[gi])
      );
    end
  endgenerate

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  always_comb begin
    mask_d = mask_q;
    if (wr && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];

    // Clear first, then OR in new edges so a same-cycle set wins.
    edge_d = edge_q;
    if (wr && address == ADDR_EDGECAP) edge_d = edge_d & ~writedata[WIDTH-1:0];
    edge_d = edge_d | (stable ^ stable_dly_q);

    irq_d = |(edge_q & mask_q);

    // Mux uses current register contents, so a read alongside a write
    // returns the pre-write value.
    readdata_d = '0;
    case (address)
      ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edge_q;
      ADDR_RAW:     readdata_d[WIDTH-1:0] = raw;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_dly_q <= '0;
      mask_q       <= '0;
      edge_q       <= '0;
      readdata_q   <= '0;
      irq_q        <= 1'b0;
    end else begin
      stable_dly_q <= stable;
      mask_q       <= mask_d;
      edge_q       <= edge_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: doc/hpsfpga_sw_irq_ctrl.md
Name: hpsfpga_sw_irq_ctrl

Overview:
- Avalon-MM slave controller for the 10-bit slide-switch input port.
- Per-bit path: synchronise, then debounce.
- Captures debounced changes in a W1C edge register and raises a maskable level interrupt to the HPS.
- Sits between the board switch pins and the lightweight HPS-to-FPGA bridge, replacing the bare polled input port.

Parameters:
- WIDTH, 10: number of switch inputs.
- DEBOUNCE_CYCLES, 500000: consecutive differing cycles required to accept a new level (10 ms at 50 MHz). Legal range 2 to 2^CNT_W-1.
- CNT_W, 20: width of each per-bit debounce counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is chipselect & !write_n.
- writedata  in  32  write data.
- readdata  out  32  registered read data, read latency 1.
- in_port  in  WIDTH  raw asynchronous switch levels.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: all state clears asynchronously on reset_n low. This covers sync flops, stable, counters, irqmask, edgecapture, readdata=0 and irq=0.
- Reset mid-debounce discards progress. After release, any switch held high re-qualifies from zero.
- Register map; bits above WIDTH read 0 and ignore writes:
  - 0 DATA, RO: debounced stable[WIDTH-1:0].
  - 1 IRQMASK, RW: per-bit interrupt enable.
  - 2 EDGECAPTURE, RW1C: writing 1 clears a bit, writing 0 has no effect.
  - 3 RAW, RO: synchronised in_port (sync2).
  - Writes to addresses 0 and 3 are ignored.
- Synchroniser: two flops per bit, sync1 <= in_port and sync2 <= sync1.
- Per-bit debounce FSM; states and transitions:
  - STABLE: counter=0. If sync2 != stable, go to COUNTING with counter=1.
  - COUNTING, sync2 == stable (glitch): counter=0, go to STABLE; stable unchanged.
  - COUNTING, sync2 != stable, counter == DEBOUNCE_CYCLES-1: stable <= sync2, counter=0, go to STABLE.
  - COUNTING, otherwise: counter+1.
- Latency: let edge k be the first edge at which sync1 samples the new level, held steady. Then:
  - stable updates at edge k+DEBOUNCE_CYCLES+1;
  - edgecapture sets at +1 edge after that;
  - irq asserts at +1 edge after edgecapture.
- Counter never exceeds DEBOUNCE_CYCLES-1. There is no wrap.
- Edge detect: stable_d is stable delayed one cycle. edgecapture[i] sets when stable[i] != stable_d[i], on both rising and falling edges, and stays sticky until cleared.
- Same-cycle set and W1C clear on one bit: set wins and the bit stays 1.
- irq is registered: irq <= |(edgecapture & irqmask), updated every cycle. Writing the mask to 0 drops irq one cycle later.
- readdata is updated every clock from the address mux, independent of a read strobe, zero-extended to 32 bits.
- A read in the same cycle as a write sees pre-write register contents.

Decomposition:
- Shared package hpsfpga_sw_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2, ADDR_RAW=3;
  - the debounce state enum {DB_STABLE, DB_COUNTING}.
- One sub-module, hpsfpga_sw_debounce_bit: 2-flop sync, counter and FSM for one bit. Instantiated WIDTH times via generate. The top level holds the register file, edge capture and irq.

Test Plan (WIDTH=10, DEBOUNCE_CYCLES=4):
- Reset: hold reset_n low with in_port=10'h3FF -> readdata=0 and irq=0. Release -> DATA reads 0x3FF only after the 5th edge post-release; EDGECAPTURE=0x3FF.
- Clean edge: in_port[0] 0->1 steady, first sampled at edge k -> DATA[0]=1 at edge k+5, EDGECAPTURE[0]=1 at k+6. With IRQMASK=0x001, irq=1 at k+7.
- Glitch rejection: in_port[3] high for 3 cycles then low -> DATA[3] stays 0, EDGECAPTURE stays 0, irq stays 0.
- W1C and masking:
  - with EDGECAPTURE=0x005 and IRQMASK=0x004, irq=1;
  - write 0x004 to address 2 -> EDGECAPTURE=0x001, irq=0 next cycle;
  - writing 0 to address 2 changes nothing.
- Set/clear collision: a W1C of bit 1 in the exact cycle bit 1's stable value toggles -> EDGECAPTURE[1] remains 1.
- Register isolation:
  - writes to addresses 0 and 3 are ignored;
  - IRQMASK write of 0xFFFFFFFF reads back 0x3FF;
  - RAW tracks in_port 2 cycles later, undebounced.
